// File: rtl/cpu_stat_pkg.sv
// Shared definitions for the pipeline statistics block.
package cpu_stat_pkg;

  // Default counter width used by perf_counter.
  localparam int unsigned STAT_WIDTH = 32;

  // Run/halt state of the statistics block.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } stat_state_t;

endpackage : cpu_stat_pkg

// File: rtl/stat_cnt.sv
// WIDTH-bit event counter with synchronous clear and optional saturation.
module stat_cnt #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic at_max;

  assign at_max = (count == '1);

  // Reset and clear take priority over counting; a full counter either holds or wraps.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      if ((SATURATE != 0) && at_max) begin
        count <= count;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule : stat_cnt

// File: rtl/perf_counter.sv
// Pipeline statistics: cycle, jump, branch and taken-branch counts, frozen while halted.
module perf_counter
  import cpu_stat_pkg::*;
#(
  parameter int unsigned WIDTH    = STAT_WIDTH,
  parameter int unsigned SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_valid,
  input  logic             is_jump,
  input  logic             is_branch,
  input  logic             branch_taken,
  input  logic             halt,
  input  logic             go,
  input  logic             clear,
  output logic [WIDTH-1:0] all_time,
  output logic [WIDTH-1:0] j_change,
  output logic [WIDTH-1:0] b_change,
  output logic [WIDTH-1:0] b_change_success,
  output logic             running
);

  stat_state_t state;
  stat_state_t state_next;
  logic        go_q;
  logic        go_rise;
  logic        in_run;

  // Go edge detector; loading the live level during reset means a held button makes no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      go_q <= go;
    end else begin
      go_q <= go;
    end
  end

  assign go_rise = go & ~go_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: halt only matters in RUN, go edge only matters in HALT.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN:  if (halt)    state_next = ST_HALT;
      ST_HALT: if (go_rise) state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  // Output decode: running doubles as the pipeline enable.
  always_comb begin
    running = 1'b0;
    in_run  = 1'b0;
    if (state == ST_RUN) begin
      running = 1'b1;
      in_run  = 1'b1;
    end
  end

  stat_cnt #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_all_time (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (in_run),
    .count (all_time)
  );

  stat_cnt #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_j_change (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (in_run & inst_valid & is_jump),
    .count (j_change)
  );

  stat_cnt #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_b_change (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (in_run & inst_valid & is_branch),
    .count (b_change)
  );

  stat_cnt #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_b_change_success (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (in_run & inst_valid & is_branch & branch_taken),
    .count (b_change_success)
  );

endmodule : perf_counter

// File: tb/tb_perf_counter.sv
// Directed bench for perf_counter: default 32-bit instance plus 4-bit saturating and wrapping instances.
module tb_perf_counter;

  logic clk = 1'b0;
  logic reset, inst_valid, is_jump, is_branch, branch_taken, halt, go, clear;

  logic [31:0] at, jc, bc, bs;
  logic        run;
  logic [3:0]  s_at, s_jc, s_bc, s_bs;
  logic        s_run;
  logic [3:0]  w_at, w_jc, w_bc, w_bs;
  logic        w_run;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_counter dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .is_jump(is_jump),
    .is_branch(is_branch), .branch_taken(branch_taken), .halt(halt), .go(go),
    .clear(clear), .all_time(at), .j_change(jc), .b_change(bc),
    .b_change_success(bs), .running(run)
  );

  perf_counter #(.WIDTH(4), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .is_jump(is_jump),
    .is_branch(is_branch), .branch_taken(branch_taken), .halt(halt), .go(go),
    .clear(clear), .all_time(s_at), .j_change(s_jc), .b_change(s_bc),
    .b_change_success(s_bs), .running(s_run)
  );

  perf_counter #(.WIDTH(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .is_jump(is_jump),
    .is_branch(is_branch), .branch_taken(branch_taken), .halt(halt), .go(go),
    .clear(clear), .all_time(w_at), .j_change(w_jc), .b_change(w_bc),
    .b_change_success(w_bs), .running(w_run)
  );

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ev(input logic v, input logic j, input logic b, input logic t);
    inst_valid = v; is_jump = j; is_branch = b; branch_taken = t;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_ev(1'b1, 1'b1, 1'b1, 1'b1);
    halt = 1'b0; go = 1'b0; clear = 1'b0;
    do_reset();
    set_ev(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (at !== 32'd0) begin bad++; $display("FAIL reset_all_time got=%0d exp=0", at); end
    total++; if (jc !== 32'd0) begin bad++; $display("FAIL reset_j_change got=%0d exp=0", jc); end
    total++; if (bc !== 32'd0) begin bad++; $display("FAIL reset_b_change got=%0d exp=0", bc); end
    total++; if (bs !== 32'd0) begin bad++; $display("FAIL reset_b_success got=%0d exp=0", bs); end
    total++; if (run !== 1'b1) begin bad++; $display("FAIL reset_running got=%0b exp=1", run); end
    tick(10);
    total++; if (at !== 32'd10) begin bad++; $display("FAIL idle_all_time got=%0d exp=10", at); end
    total++; if ((jc | bc | bs) !== 32'd0) begin bad++; $display("FAIL idle_events got=%0d/%0d/%0d exp=0/0/0", jc, bc, bs); end
    total++; if (run !== 1'b1) begin bad++; $display("FAIL idle_running got=%0b exp=1", run); end
  endtask

  task automatic test_events();
    do_reset();
    set_ev(1'b1, 1'b1, 1'b0, 1'b0); tick(1);          // jump
    total++; if (jc !== 32'd1) begin bad++; $display("FAIL jump_latency got=%0d exp=1", jc); end
    set_ev(1'b1, 1'b0, 1'b1, 1'b1); tick(1);          // branch taken
    set_ev(1'b1, 1'b0, 1'b1, 1'b0); tick(1);          // branch not taken
    set_ev(1'b0, 1'b1, 1'b0, 1'b0); tick(1);          // bubble flagged as jump
    set_ev(1'b1, 1'b0, 1'b0, 1'b1); tick(1);          // taken without branch
    set_ev(1'b0, 1'b0, 1'b1, 1'b1); tick(1);          // bubble flagged as taken branch
    set_ev(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (jc !== 32'd1) begin bad++; $display("FAIL seq_j_change got=%0d exp=1", jc); end
    total++; if (bc !== 32'd2) begin bad++; $display("FAIL seq_b_change got=%0d exp=2", bc); end
    total++; if (bs !== 32'd1) begin bad++; $display("FAIL seq_b_success got=%0d exp=1", bs); end
    total++; if (at !== 32'd6) begin bad++; $display("FAIL seq_all_time got=%0d exp=6", at); end
    set_ev(1'b1, 1'b1, 1'b1, 1'b1); tick(1);          // jump+branch together counts both
    set_ev(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (jc !== 32'd2 || bc !== 32'd3 || bs !== 32'd2) begin
      bad++; $display("FAIL both_flags got=%0d/%0d/%0d exp=2/3/2", jc, bc, bs);
    end
  endtask

  task automatic test_halt_resume();
    go = 1'b1;
    do_reset();
    tick(5);
    total++; if (at !== 32'd5) begin bad++; $display("FAIL pre_halt_all_time got=%0d exp=5", at); end
    halt = 1'b1;
    set_ev(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1);
    total++; if (at !== 32'd6) begin bad++; $display("FAIL halt_edge_all_time got=%0d exp=6", at); end
    total++; if (run !== 1'b0) begin bad++; $display("FAIL halt_running got=%0b exp=0", run); end
    total++; if (jc !== 32'd1 || bc !== 32'd1 || bs !== 32'd1) begin
      bad++; $display("FAIL halt_edge_events got=%0d/%0d/%0d exp=1/1/1", jc, bc, bs);
    end
    halt = 1'b0;
    tick(20);
    total++; if (at !== 32'd6) begin bad++; $display("FAIL halted_all_time got=%0d exp=6", at); end
    total++; if (jc !== 32'd1 || bc !== 32'd1 || bs !== 32'd1) begin
      bad++; $display("FAIL halted_events got=%0d/%0d/%0d exp=1/1/1", jc, bc, bs);
    end
    total++; if (run !== 1'b0) begin bad++; $display("FAIL held_go_no_resume got=%0b exp=0", run); end
    set_ev(1'b0, 1'b0, 1'b0, 1'b0);
    go = 1'b0; tick(1);
    go = 1'b1; tick(1);
    total++; if (run !== 1'b1) begin bad++; $display("FAIL go_resume_running got=%0b exp=1", run); end
    total++; if (at !== 32'd6) begin bad++; $display("FAIL go_resume_all_time got=%0d exp=6", at); end
    tick(1);
    total++; if (at !== 32'd7) begin bad++; $display("FAIL resumed_all_time got=%0d exp=7", at); end
    go = 1'b0; tick(1);
    go = 1'b1; tick(1);                               // go edge in RUN is ignored
    total++; if (run !== 1'b1 || at !== 32'd9) begin
      bad++; $display("FAIL go_in_run got=%0b/%0d exp=1/9", run, at);
    end
    go = 1'b0;
  endtask

  task automatic test_go_halt_same();
    do_reset();
    halt = 1'b1; tick(1);
    total++; if (run !== 1'b0) begin bad++; $display("FAIL gh_halt got=%0b exp=0", run); end
    go = 1'b1; tick(1);                               // go edge with halt still high
    total++; if (run !== 1'b1) begin bad++; $display("FAIL gh_go_wins got=%0b exp=1", run); end
    go = 1'b0; tick(1);                               // halt still high in RUN
    total++; if (run !== 1'b0) begin bad++; $display("FAIL gh_rehalt got=%0b exp=0", run); end
    halt = 1'b0;
    do_reset();                                       // reset from HALT returns to RUN
    total++; if (run !== 1'b1 || at !== 32'd0) begin
      bad++; $display("FAIL reset_from_halt got=%0b/%0d exp=1/0", run, at);
    end
  endtask

  task automatic test_clear();
    do_reset();
    set_ev(1'b1, 1'b1, 1'b0, 1'b0); tick(3);
    total++; if (jc !== 32'd3) begin bad++; $display("FAIL pre_clear_j got=%0d exp=3", jc); end
    set_ev(1'b1, 1'b0, 1'b1, 1'b1);
    clear = 1'b1; tick(1);
    clear = 1'b0;
    set_ev(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if ((at | jc | bc | bs) !== 32'd0) begin
      bad++; $display("FAIL clear_run got=%0d/%0d/%0d/%0d exp=0/0/0/0", at, jc, bc, bs);
    end
    total++; if (run !== 1'b1) begin bad++; $display("FAIL clear_run_state got=%0b exp=1", run); end
    tick(2);
    halt = 1'b1; tick(1);
    halt = 1'b0;
    total++; if (at !== 32'd3) begin bad++; $display("FAIL pre_clear_halt got=%0d exp=3", at); end
    clear = 1'b1; tick(1);
    clear = 1'b0;
    total++; if (at !== 32'd0 || run !== 1'b0) begin
      bad++; $display("FAIL clear_halt got=%0d/%0b exp=0/0", at, run);
    end
    go = 1'b1; tick(2);
    go = 1'b0;
    total++; if (at !== 32'd1 || run !== 1'b1) begin
      bad++; $display("FAIL clear_then_go got=%0d/%0b exp=1/1", at, run);
    end
  endtask

  task automatic test_width();
    do_reset();
    set_ev(1'b1, 1'b0, 1'b1, 1'b1);
    tick(17);
    total++; if (w_at !== 4'd1) begin bad++; $display("FAIL wrap_all_time got=%0d exp=1", w_at); end
    total++; if (w_bs !== 4'd1) begin bad++; $display("FAIL wrap_b_success got=%0d exp=1", w_bs); end
    total++; if (s_at !== 4'd15) begin bad++; $display("FAIL sat17_all_time got=%0d exp=15", s_at); end
    tick(3);
    set_ev(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (s_at !== 4'd15) begin bad++; $display("FAIL sat20_all_time got=%0d exp=15", s_at); end
    total++; if (s_bc !== 4'd15 || s_bs !== 4'd15) begin
      bad++; $display("FAIL sat_events got=%0d/%0d exp=15/15", s_bc, s_bs);
    end
    total++; if (w_at !== 4'd4) begin bad++; $display("FAIL wrap20_all_time got=%0d exp=4", w_at); end
    total++; if (at !== 32'd20) begin bad++; $display("FAIL wide20_all_time got=%0d exp=20", at); end
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; go = 1'b0; clear = 1'b0;
    set_ev(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_events();
    test_halt_resume();
    test_go_halt_same();
    test_clear();
    test_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_perf_counter
